// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, fault codes,
// controller states and the load lane-extract/extend helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_FUNCT3   = 2'd3;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } mem_state_t;

    // Pick the addressed byte/half out of a little-endian word, then extend.
    function automatic logic [31:0] load_extend(input logic [31:0] i_word,
                                                input logic [2:0]  i_f3,
                                                input logic [1:0]  i_lane);
        logic [7:0]  w_b;
        logic [15:0] w_h;
        logic [31:0] w_r;
        w_b = i_word[{i_lane, 3'b000} +: 8];
        w_h = i_word[{i_lane[1], 4'b0000} +: 16];
        case (i_f3)
            F3_B:    w_r = {{24{w_b[7]}}, w_b};
            F3_H:    w_r = {{16{w_h[15]}}, w_h};
            F3_W:    w_r = i_word;
            F3_BU:   w_r = {24'h0, w_b};
            F3_HU:   w_r = {16'h0, w_h};
            default: w_r = '0;
        endcase
        return w_r;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH_WORDS x 32 synchronous RAM: byte-enable write port and registered
// read port. Storage is deliberately not reset.
module mem_word_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// RV32I data memory controller: valid/ready request/response, load/store
// width handling, fault detection and post-reset clear of the array.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_err_code,
    output logic              init_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // One extra bit so the limit is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS * 4);
    localparam mem_state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic INIT_RESET = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

    mem_state_t       r_state, w_next;
    logic [IDX_W-1:0] r_clr_cnt;
    logic             r_req_ready;
    logic             r_init_done;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [1:0]       r_resp_err_code;
    logic             r_ld_valid;
    logic [2:0]       r_ld_f3;
    logic [1:0]       r_ld_lane;

    logic             w_accept;
    logic             w_f3_legal;
    logic [1:0]       w_err_code;
    logic             w_ok;
    logic [1:0]       w_lane;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [31:0]      w_wdata;
    logic             w_re;
    logic [31:0]      w_arr_rdata;

    assign w_accept = req_valid & r_req_ready;
    assign w_lane   = req_addr[1:0];
    assign w_idx    = req_addr[IDX_W+1:2];

    always_comb begin
        w_f3_legal = 1'b0;
        if (req_we) begin
            w_f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        end else begin
            w_f3_legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                         (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
        end
    end

    always_comb begin
        w_err_code = ERR_NONE;
        if (!w_f3_legal)
            w_err_code = ERR_FUNCT3;
        else if (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && w_lane[0])
            w_err_code = ERR_MISALIGN;
        else if ((req_funct3 == F3_W) && (w_lane != 2'b00))
            w_err_code = ERR_MISALIGN;
        else if ({1'b0, req_addr} >= ADDR_LIMIT)
            w_err_code = ERR_RANGE;
    end

    assign w_ok = (w_err_code == ERR_NONE);
    assign w_re = w_accept & ~req_we & w_ok;

    // The single write port is shared between the clear engine and stores.
    always_comb begin
        w_we    = '0;
        w_waddr = w_idx;
        w_wdata = '0;
        if (r_state == ST_CLEAR) begin
            w_we    = '1;
            w_waddr = r_clr_cnt;
        end else if (w_accept && req_we && w_ok) begin
            case (req_funct3)
                F3_B: begin
                    w_we    = 4'b0001 << w_lane;
                    w_wdata = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    w_we    = w_lane[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_we    = '1;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_RESET;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == IDX_W'(DEPTH_WORDS - 1)) w_next = ST_IDLE;
            ST_IDLE:  if (w_accept) w_next = ST_RESP;
            ST_RESP:  if (resp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt       <= '0;
            r_req_ready     <= 1'b0;
            r_init_done     <= INIT_RESET;
            r_resp_valid    <= 1'b0;
            r_resp_err      <= 1'b0;
            r_resp_err_code <= ERR_NONE;
            r_ld_valid      <= 1'b0;
            r_ld_f3         <= '0;
            r_ld_lane       <= '0;
        end else begin
            r_req_ready <= (w_next == ST_IDLE);
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
                if (w_next == ST_IDLE) r_init_done <= 1'b1;
            end
            if (w_accept) begin
                r_resp_valid    <= 1'b1;
                r_resp_err      <= ~w_ok;
                r_resp_err_code <= w_err_code;
                r_ld_valid      <= ~req_we & w_ok;
                r_ld_f3         <= req_funct3;
                r_ld_lane       <= w_lane;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_resp_valid    <= 1'b0;
                r_resp_err      <= 1'b0;
                r_resp_err_code <= ERR_NONE;
                r_ld_valid      <= 1'b0;
            end
        end
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_idx),
        .o_rdata (w_arr_rdata)
    );

    // The array read register only updates on a load accept, so the extended
    // result stays stable for the whole response phase.
    assign resp_rdata    = r_ld_valid ? load_extend(w_arr_rdata, r_ld_f3, r_ld_lane) : '0;
    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_err      = r_resp_err;
    assign resp_err_code = r_resp_err_code;
    assign init_done     = r_init_done;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl (16-word instance) against a
// byte-array reference model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 16;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_err_code;
    logic        init_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mem_m [BYTES];

    data_memory_ctrl #(
        .DEPTH_WORDS    (DEPTH),
        .ADDR_W         (32),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .resp_err_code (resp_err_code),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I semantics over a flat little-endian byte array.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] code);
        int size;
        bit legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        rd = '0;
        code = 2'd0;
        if (!legal)                code = 2'd3;
        else if (a % size != 0)    code = 2'd1;
        else if (a >= 32'(BYTES))  code = 2'd2;
        else if (we) begin
            for (int i = 0; i < size; i++) mem_m[int'(a) + i] = 8'(wd >> (8 * i));
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
            if (f3 == 3'd0)      rd = {{24{v[7]}}, v[7:0]};
            else if (f3 == 3'd1) rd = {{16{v[15]}}, v[15:0]};
            else                 rd = v;
        end
    endtask

    task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] obs);
        logic [31:0] exp_rd;
        logic [1:0]  exp_code;
        int k;
        k = 0;
        while (!req_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        model(we, f3, a, wd, exp_rd, exp_code);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs = resp_rdata;
        chk("resp_valid_lat1", 32'(resp_valid), 32'd1);
        chk("resp_err_code", 32'(resp_err_code), 32'(exp_code));
        chk("resp_err", 32'(resp_err), 32'(exp_code != 2'd0));
        chk("resp_rdata", resp_rdata, exp_rd);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_err_code"}, 32'(resp_err_code), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    // Release reset and check the clear takes exactly DEPTH cycles.
    task automatic release_and_clear();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 1; c < DEPTH; c++) begin
            @(posedge clk); #1;
            chk("clear_ready_low", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        chk("clear_ready_high", 32'(req_ready), 32'd1);
        chk("clear_init_done", 32'(init_done), 32'd1);
        for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
    endtask

    initial begin
        logic [31:0] r, held;
        logic [31:0] a;
        logic [2:0]  f3;
        bit          we;

        #2;
        chk_reset_outputs("por");
        release_and_clear();
        xact(1'b0, 3'd2, 32'h3C, 32'h0, r);
        chk("lw_3c_cleared", r, 32'h0);

        xact(1'b1, 3'd2, 32'h10, 32'h8000_00F0, r);
        chk("sw_rdata_zero", r, 32'h0);
        xact(1'b0, 3'd0, 32'h10, 32'h0, r);
        chk("lb_10", r, 32'hFFFF_FFF0);
        xact(1'b0, 3'd4, 32'h13, 32'h0, r);
        chk("lbu_13", r, 32'h0000_0080);
        xact(1'b0, 3'd1, 32'h12, 32'h0, r);
        chk("lh_12", r, 32'hFFFF_8000);
        xact(1'b0, 3'd5, 32'h12, 32'h0, r);
        chk("lhu_12", r, 32'h0000_8000);

        xact(1'b1, 3'd0, 32'h21, 32'hFFFF_FFAB, r);
        xact(1'b0, 3'd2, 32'h20, 32'h0, r);
        chk("lw_20_after_sb", r, 32'h0000_AB00);
        xact(1'b1, 3'd1, 32'h22, 32'h5555_1234, r);
        xact(1'b0, 3'd2, 32'h20, 32'h0, r);
        chk("lw_20_after_sh", r, 32'h1234_AB00);

        xact(1'b0, 3'd2, 32'h02, 32'h0, r);
        xact(1'b0, 3'd1, 32'h40, 32'h0, r);
        xact(1'b1, 3'd5, 32'h00, 32'hDEAD_BEEF, r);
        xact(1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF, r);
        xact(1'b1, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, r);
        xact(1'b1, 3'd2, 32'h3C, 32'hCAFE_F00D, r);
        xact(1'b1, 3'd1, 32'h3E, 32'h0000_7788, r);
        xact(1'b0, 3'd2, 32'h3C, 32'h0, r);
        chk("lw_last_word", r, 32'h7788_F00D);
        xact(1'b0, 3'd2, 32'h00, 32'h0, r);
        chk("lw_00_untouched", r, 32'h0);

        // Stalled response: must hold, and a concurrent request is refused.
        xact(1'b1, 3'd2, 32'h04, 32'h1357_9BDF, r);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h04;
        @(posedge clk); #1;
        held = resp_rdata;
        chk("stall_first", held, 32'h1357_9BDF);
        req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_rdata", resp_rdata, held);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        xact(1'b0, 3'd2, 32'h04, 32'h0, r);
        chk("stall_no_write", r, 32'h1357_9BDF);

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h40 + 32'($urandom_range(0, 15));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, BYTES - 1));
            endcase
            xact(we, f3, a, $urandom, r);
        end
        for (int w = 0; w < DEPTH; w++) xact(1'b1, 3'd2, 32'(w * 4), $urandom | 32'h1, r);

        // Reset while a response is pending.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h08;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_reset_valid", 32'(resp_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_resp");
        release_and_clear();

        for (int w = 0; w < DEPTH; w++) xact(1'b1, 3'd2, 32'(w * 4), 32'hA5A5_0000 | 32'(w), r);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_clear");
        release_and_clear();
        for (int w = 0; w < DEPTH; w++) begin
            xact(1'b0, 3'd2, 32'(w * 4), 32'h0, r);
            chk("post_clear_zero", r, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
